// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: initiator state encoding and default read value.
package wb_pkg;

   localparam int unsigned DEF_RD_WIDTH = 32;

   // Value returned for reads nobody answered; also used by the responder-side default register.
   localparam logic [DEF_RD_WIDTH-1:0] DEF_RD_VALUE = 32'hDEF_FAB_AC;

   typedef enum logic [1:0] {
      WBM_IDLE = 2'd0,
      WBM_BUS  = 2'd1,
      WBM_RESP = 2'd2
   } wbm_state_e;

endpackage : wb_pkg

// File: rtl/wb_ack_timer.sv
// Ack-timeout counter: load to CYCLES, decrement per waiting cycle, flag the last allowed cycle.
module wb_ack_timer #(
   parameter int unsigned CNTR_WIDTH = 4,
   parameter int unsigned CYCLES     = 12
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic load_i,
   input  logic dec_i,
   output logic last_c_o
);

   logic [CNTR_WIDTH-1:0] cnt_q;
   logic [CNTR_WIDTH-1:0] cnt_d;

   // Next count: reload has priority, decrement never wraps below zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNTR_WIDTH'(CYCLES);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNTR_WIDTH'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= CNTR_WIDTH'(CYCLES);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_c_o = (cnt_q == CNTR_WIDTH'(1));

endmodule : wb_ack_timer

// File: rtl/wb_cmd_master.sv
// Single-beat command-to-Wishbone initiator with optional ack timeout.
// Optional feature macro: WB_CMD_MASTER_TIMEOUT_EN (builds the ack timer and abort path).
module wb_cmd_master
   import wb_pkg::*;
#(
   parameter int unsigned ADDRWIDTH          = 10,
   parameter int unsigned DATAWIDTH          = 32,
   parameter int unsigned TIMEOUT_CNTR_WIDTH = 4,
   parameter int unsigned TIMEOUT_CYCLES     = 12,
   parameter logic [DATAWIDTH-1:0] TIMEOUT_RD_VALUE = DATAWIDTH'(DEF_RD_VALUE)
) (
   input  logic                   WBs_CLK_i,
   input  logic                   WBs_RST_n_i,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic                   cmd_we_i,
   input  logic [ADDRWIDTH-1:0]   cmd_adr_i,
   input  logic [DATAWIDTH-1:0]   cmd_dat_i,
   input  logic [DATAWIDTH/8-1:0] cmd_sel_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [DATAWIDTH-1:0]   rsp_dat_o,
   output logic                   rsp_err_o,
   output logic [ADDRWIDTH-1:0]   WBm_ADR_o,
   output logic                   WBm_CYC_o,
   output logic                   WBm_STB_o,
   output logic                   WBm_WE_o,
   output logic [DATAWIDTH/8-1:0] WBm_BYTE_STB_o,
   output logic [DATAWIDTH-1:0]   WBm_DAT_o,
   input  logic [DATAWIDTH-1:0]   WBm_DAT_i,
   input  logic                   WBm_ACK_i
);

   localparam int unsigned SELWIDTH = DATAWIDTH / 8;

   wbm_state_e state_q, state_d;

   logic                 cmd_ready_q, cmd_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DATAWIDTH-1:0] rsp_dat_q,   rsp_dat_d;
   logic                 rsp_err_q,   rsp_err_d;
   logic [ADDRWIDTH-1:0] adr_q,       adr_d;
   logic                 cyc_q,       cyc_d;
   logic                 stb_q,       stb_d;
   logic                 we_q,        we_d;
   logic [SELWIDTH-1:0]  sel_q,       sel_d;
   logic [DATAWIDTH-1:0] dat_q,       dat_d;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   logic tmr_load_c;
   logic tmr_dec_c;
   logic tmr_last_c;

   wb_ack_timer #(
      .CNTR_WIDTH (TIMEOUT_CNTR_WIDTH),
      .CYCLES     (TIMEOUT_CYCLES)
   ) u_ack_timer (
      .clk_i    (WBs_CLK_i),
      .rst_n_i  (WBs_RST_n_i),
      .load_i   (tmr_load_c),
      .dec_i    (tmr_dec_c),
      .last_c_o (tmr_last_c)
   );
`else
   // Timeout parameters have no function in this build.
   logic unused_timeout_c;
   assign unused_timeout_c = ^{TIMEOUT_RD_VALUE, 32'(TIMEOUT_CYCLES), 32'(TIMEOUT_CNTR_WIDTH)};
`endif

   // State register.
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         state_q <= WBM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and registered-output next values.
   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      adr_d       = adr_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      dat_d       = dat_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      tmr_load_c  = 1'b0;
      tmr_dec_c   = 1'b0;
`endif
      unique case (state_q)
         WBM_IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               adr_d   = cmd_adr_i;
               dat_d   = cmd_dat_i;
               sel_d   = cmd_sel_i;
               we_d    = cmd_we_i;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               state_d = WBM_BUS;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
               tmr_load_c = 1'b1;
`endif
            end
         end
         WBM_BUS: begin
            if (WBm_ACK_i) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_dat_d   = we_q ? '0 : WBm_DAT_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = WBM_RESP;
            end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            else if (tmr_last_c) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_dat_d   = we_q ? '0 : TIMEOUT_RD_VALUE;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = WBM_RESP;
            end else begin
               tmr_dec_c = 1'b1;
            end
`endif
         end
         WBM_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = WBM_IDLE;
            end
         end
         default: begin
            state_d = WBM_IDLE;
         end
      endcase
      cmd_ready_d = (state_d == WBM_IDLE);
   end

   // Output registers; reset discards any transfer or pending response.
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         adr_q       <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         dat_q       <= '0;
      end else begin
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         adr_q       <= adr_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         dat_q       <= dat_d;
      end
   end

   assign cmd_ready_o    = cmd_ready_q;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_dat_o      = rsp_dat_q;
   assign rsp_err_o      = rsp_err_q;
   assign WBm_ADR_o      = adr_q;
   assign WBm_CYC_o      = cyc_q;
   assign WBm_STB_o      = stb_q;
   assign WBm_WE_o       = we_q;
   assign WBm_BYTE_STB_o = sel_q;
   assign WBm_DAT_o      = dat_q;

endmodule : wb_cmd_master
